// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide unit with start/busy/done handshake and flush.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MDU_result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t            state, state_n;
    logic [2:0]        op;
    logic              sa, sb;
    logic [XLEN-1:0]   opd;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [CW-1:0]     cnt;
    logic [XLEN:0]     sum, diff;
    logic              is_div, a_sg, b_sg, in_an, in_bn, dz, ov, fast, accept;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, idle_res, res_n;

    // Sign-corrects a magnitude product, or a {remainder, quotient} pair, and selects the result.
    function automatic logic [XLEN-1:0] pick(input logic [2:0] f, input logic an, input logic bn,
                                             input logic [2*XLEN-1:0] p);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem;
        prod = (an ^ bn) ? -p : p;
        quo  = (an ^ bn) ? -p[XLEN-1:0] : p[XLEN-1:0];
        rem  = an ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
        return f == 3'b000 ? prod[XLEN-1:0] : !f[2] ? prod[2*XLEN-1:XLEN] : !f[1] ? quo : rem;
    endfunction

    assign is_div   = funct3[2];
    assign a_sg     = is_div ? !funct3[0] : funct3 != 3'b011;
    assign b_sg     = is_div ? !funct3[0] : !funct3[1];
    assign in_an    = a_sg & read_data1[XLEN-1];
    assign in_bn    = b_sg & read_data2[XLEN-1];
    assign mag_a    = in_an ? -read_data1 : read_data1;
    assign mag_b    = in_bn ? -read_data2 : read_data2;
    assign dz       = is_div && read_data2 == '0;
    assign ov       = is_div && !funct3[0] && read_data1 == {1'b1, {(XLEN-1){1'b0}}} && read_data2 == '1;
    assign spec_res = dz ? (funct3[1] ? read_data1 : '1) : (funct3[1] ? '0 : read_data1);
    assign accept   = state == IDLE && start && !flush;
    assign busy     = state != IDLE;
    assign done     = state == FINISH;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
    assign fprod    = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast     = !is_div;
    assign idle_res = (dz || ov) ? spec_res : pick(funct3, in_an, in_bn, fprod);
`else
    assign fast     = 1'b0;
    assign idle_res = spec_res;
`endif

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        diff  = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        acc_n = op[2] ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                      : {sum, acc[XLEN-1:1]};
        res_n = state == IDLE ? idle_res : pick(op, sa, sb, acc_n);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((dz || ov || fast) ? FINISH : CALC) : IDLE;
            CALC:    state_n = cnt == CW'(XLEN - 1) ? FINISH : CALC;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            MDU_result <= '0;
            op         <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            opd        <= '0;
            acc        <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == CALC ? cnt + 1'b1 : '0;
            if (state_n == FINISH) MDU_result <= res_n;
            if (accept) begin
                op  <= funct3;
                sa  <= in_an;
                sb  <= in_bn;
                opd <= is_div ? mag_b : mag_a;
                acc <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            end else if (state == CALC) begin
                acc <= acc_n;
            end
        end
    end
endmodule
